uart_autobaud_ctrl: RTL

UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

---
 rtl/uart_autobaud_ctrl_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_autobaud_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared UART definitions: auto-baud FSM encoding and the count/divisor widths
// used by the auto-baud controller.
package uart_autobaud_ctrl_pkg;

  localparam int CNT_W  = 17;
  localparam int BAUD_W = 13;
  localparam int FRAC_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IDLE  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_CALC       = 3'd4
  } ab_state_e;

  // A measured low time of N clocks is one bit at 16x oversampling, so the
  // integer divisor is N/16 - 1 and the fraction is the remaining eighths.
  function automatic logic [BAUD_W-1:0] calc_baud(input logic [CNT_W-1:0] n);
    calc_baud = n[CNT_W-1:4] - 13'd1;
  endfunction

  function automatic logic [FRAC_W-1:0] calc_frac(input logic [CNT_W-1:0] n);
    calc_frac = n[3:1];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: after an idle period, times the start-bit low pulse on rx
// and converts it to a 16x baud divisor (integer + eighths).
module uart_autobaud_ctrl
  import uart_autobaud_ctrl_pkg::*;
#(
  parameter logic [BAUD_W-1:0] DEFAULT_BAUD_VAL = 13'd1,
  parameter int                IDLE_CYCLES      = 64,
  parameter int                MIN_COUNT        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              arm,
  input  logic              abort,
  output logic [BAUD_W-1:0] baud_val,
  output logic [FRAC_W-1:0] baud_val_fraction,
  output logic              cfg_valid,
  output logic              locked,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  logic rx_s;

  ab_state_e         state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [BAUD_W-1:0] baud_val_q, baud_val_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              locked_q, locked_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic [IDLE_W-1:0] idle_inc;

  uart_rx_sync u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s)
  );

  assign idle_inc = idle_cnt_q + IDLE_W'(1);

  // Priority: abort, then arm (restart), then the measurement FSM itself.
  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    n_d           = n_q;
    baud_val_d    = baud_val_q;
    frac_d        = frac_q;
    cfg_valid_d   = 1'b0;
    locked_d      = locked_q;
    timeout_err_d = timeout_err_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d       = ST_WAIT_IDLE;
      idle_cnt_d    = {IDLE_W{1'b0}};
      n_d           = {CNT_W{1'b0}};
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            idle_cnt_d = idle_inc;
            if (idle_inc == IDLE_W'(IDLE_CYCLES)) begin
              state_d = ST_WAIT_START;
            end else begin
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            idle_cnt_d = {IDLE_W{1'b0}};
          end
        end
        ST_WAIT_START: begin
          if (!rx_s) begin
            n_d     = 17'd1;
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_WAIT_START;
          end
        end
        ST_MEASURE: begin
          if (rx_s) begin
            state_d = ST_CALC;
          end else if (n_q == CNT_MAX) begin
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            n_d = n_q + 17'd1;
          end
        end
        ST_CALC: begin
          // Too short to be a start bit: treat as a glitch and wait for idle again.
          if (n_q < CNT_W'(MIN_COUNT)) begin
            idle_cnt_d = {IDLE_W{1'b0}};
            state_d    = ST_WAIT_IDLE;
          end else begin
            baud_val_d  = calc_baud(n_q);
            frac_d      = calc_frac(n_q);
            cfg_valid_d = 1'b1;
            locked_d    = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idle_cnt_q    <= {IDLE_W{1'b0}};
      n_q           <= {CNT_W{1'b0}};
      baud_val_q    <= DEFAULT_BAUD_VAL;
      frac_q        <= {FRAC_W{1'b0}};
      cfg_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      n_q           <= n_d;
      baud_val_q    <= baud_val_d;
      frac_q        <= frac_d;
      cfg_valid_q   <= cfg_valid_d;
      locked_q      <= locked_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign baud_val          = baud_val_q;
  assign baud_val_fraction = frac_q;
  assign cfg_valid         = cfg_valid_q;
  assign locked            = locked_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_err_q;

endmodule
